// File: rtl/pps_pkg.sv
// Shared types and helpers for the PPS timebase.
// Imported by the timebase top level.
package pps_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2,
    HOLDOVER = 2'd3
  } pps_state_t;

  // Written as period+tol >= nominal so that nominal < tol cannot underflow.
  function automatic logic period_good(
    input logic [63:0] period,
    input logic [63:0] nominal,
    input logic [63:0] tol
  );
    return (period + tol >= nominal) && (period <= nominal + tol);
  endfunction

endpackage

// File: rtl/pps_sync_edge.sv
// Multi-flop synchronizer for the PPS strobe.
// Emits a single-cycle pulse on each synced rising edge.
module pps_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic axi_aclk,
  input  logic axi_aresetn,
  input  logic pps_in,
  output logic pps_edge
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q[0] <= pps_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pps_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/pps_timebase.sv
// Seconds/sub-second timebase disciplined by a PPS strobe.
// Flywheels through missing pulses; snapshots, lock status, irq.
module pps_timebase
  import pps_pkg::*;
#(
  parameter int NOMINAL     = 1000000,
  parameter int TOL         = 1000,
  parameter int LOCK_N      = 3,
  parameter int SUBSEC_W    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                axi_aclk,
  input  logic                axi_aresetn,
  input  logic                pps_in,
  input  logic                snap_req,
  input  logic                irq_ack,
  output logic [31:0]         seconds,
  output logic [SUBSEC_W-1:0] subsec,
  output logic [SUBSEC_W-1:0] last_period,
  output logic [31:0]         snap_seconds,
  output logic [SUBSEC_W-1:0] snap_subsec,
  output logic                snap_valid,
  output logic                locked,
  output logic                holdover,
  output logic                pps_err,
  output logic                irq
);

  localparam int CW = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);
  localparam logic [CW-1:0] LOCK_MAX = CW'(LOCK_N);
  localparam logic [SUBSEC_W-1:0] SUB_MAX = '1;
  localparam logic [SUBSEC_W-1:0] NOM_M1 = SUBSEC_W'(NOMINAL - 1);
  localparam logic [SUBSEC_W-1:0] HALF = SUBSEC_W'(NOMINAL / 2);
  localparam logic [SUBSEC_W-1:0] TOL_V = SUBSEC_W'(TOL);
  // Timeout fires on the cycle the counter would step onto NOMINAL+TOL.
  localparam logic [SUBSEC_W-1:0] TMO = SUBSEC_W'(NOMINAL + TOL - 1);

  pps_state_t state, state_d;
  logic [CW-1:0] lock_cnt, lock_d;
  logic [31:0] sec_d;
  logic [SUBSEC_W-1:0] sub_d, last_d, sub_inc;
  logic pps_edge, good, irq_set, err_set;

  pps_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .axi_aclk   (axi_aclk),
    .axi_aresetn(axi_aresetn),
    .pps_in     (pps_in),
    .pps_edge   (pps_edge)
  );

  assign sub_inc = subsec + 1'b1;
  assign good = period_good(64'(subsec) + 64'd1,
                            64'(NOMINAL), 64'(TOL));

  always_comb begin
    state_d = state;
    lock_d  = lock_cnt;
    sec_d   = seconds;
    sub_d   = sub_inc;
    last_d  = last_period;
    irq_set = 1'b0;
    err_set = 1'b0;
    if (pps_edge) begin
      last_d = sub_inc;
      sub_d  = '0;
    end
    unique case (state)
      UNLOCKED: begin
        if (pps_edge) begin
          state_d = LOCKING;
          lock_d  = '0;
        end else if (subsec == SUB_MAX) begin
          sub_d = subsec;
        end
      end
      LOCKING: begin
        if (pps_edge) begin
          sec_d = seconds + 32'd1;
          if (good) begin
            lock_d = lock_cnt + 1'b1;
            if (lock_d == LOCK_MAX) state_d = LOCKED;
          end else begin
            lock_d = '0;
          end
        end else if (subsec == TMO) begin
          state_d = UNLOCKED;
        end
      end
      LOCKED: begin
        if (pps_edge) begin
          sec_d   = seconds + 32'd1;
          irq_set = 1'b1;
          if (!good) begin
            err_set = 1'b1;
            state_d = LOCKING;
            lock_d  = '0;
          end
        end else if (subsec == TMO) begin
          state_d = HOLDOVER;
          sec_d   = seconds + 32'd1;
          sub_d   = TOL_V;
          irq_set = 1'b1;
        end
      end
      HOLDOVER: begin
        if (pps_edge) begin
          state_d = LOCKING;
          lock_d  = '0;
          // Early half: the flywheel already counted this second.
          if (subsec >= HALF) sec_d = seconds + 32'd1;
        end else if (subsec == NOM_M1) begin
          sub_d = '0;
          sec_d = seconds + 32'd1;
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state        <= UNLOCKED;
      lock_cnt     <= '0;
      seconds      <= '0;
      subsec       <= '0;
      last_period  <= '0;
      snap_seconds <= '0;
      snap_subsec  <= '0;
      snap_valid   <= 1'b0;
      pps_err      <= 1'b0;
      irq          <= 1'b0;
    end else begin
      state       <= state_d;
      lock_cnt    <= lock_d;
      seconds     <= sec_d;
      subsec      <= sub_d;
      last_period <= last_d;
      snap_valid  <= snap_req;
      if (snap_req) begin
        snap_seconds <= seconds;
        snap_subsec  <= subsec;
      end
      irq     <= irq_set | (irq & ~irq_ack);
      pps_err <= err_set | (pps_err & ~irq_ack);
    end
  end

  assign locked   = (state == LOCKED);
  assign holdover = (state == HOLDOVER);

endmodule

// File: tb/tb_pps_timebase.sv
// Bench for pps_timebase: lock table, corner sequences, random run.
// A timestamp-based reference model is compared every cycle.
module tb_pps_timebase;

  localparam int NOM = 100;
  localparam int TOL = 2;
  localparam int LOCKN = 3;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pps_in = 1'b0;
  logic snap_req = 1'b0;
  logic irq_ack = 1'b0;
  logic [31:0] seconds, subsec, last_period, snap_seconds, snap_subsec;
  logic snap_valid, locked, holdover, pps_err, irq;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pps_timebase #(
    .NOMINAL(NOM), .TOL(TOL), .LOCK_N(LOCKN),
    .SUBSEC_W(32), .SYNC_STAGES(S)
  ) dut (
    .axi_aclk    (clk),
    .axi_aresetn (rst_n),
    .pps_in      (pps_in),
    .snap_req    (snap_req),
    .irq_ack     (irq_ack),
    .seconds     (seconds),
    .subsec      (subsec),
    .last_period (last_period),
    .snap_seconds(snap_seconds),
    .snap_subsec (snap_subsec),
    .snap_valid  (snap_valid),
    .locked      (locked),
    .holdover    (holdover),
    .pps_err     (pps_err),
    .irq         (irq)
  );

  typedef enum {FREE, ACQ, TRACK, FLY} mmode_t;
  mmode_t mode;
  int run;
  longint t = 0;
  longint anchor = 0;
  logic [31:0] m_sec, m_last, m_ssec, m_ssub;
  bit m_sv, m_err, m_irq;
  bit hist[$];

  // Sub-second value is elapsed time since the current anchor.
  function automatic logic [31:0] m_sub();
    longint d = t - anchor;
    if (d > 64'd4294967295) return 32'hFFFF_FFFF;
    return d[31:0];
  endfunction

  task automatic model_reset();
    mode = FREE; run = 0; anchor = t;
    m_sec = 0; m_last = 0; m_ssec = 0; m_ssub = 0;
    m_sv = 0; m_err = 0; m_irq = 0;
    hist.delete();
    repeat (S + 2) hist.push_back(1'b0);
  endtask

  task automatic model_step();
    longint s, p;
    bit e, ok, iset, eset;
    if (!rst_n) begin
      t++;
      model_reset();
      return;
    end
    hist.push_front(pps_in);
    void'(hist.pop_back());
    e = hist[S] && !hist[S+1];
    s = longint'(m_sub());
    p = s + 1;
    t++;
    ok = (p + TOL >= NOM) && (p <= NOM + TOL);
    iset = 0;
    eset = 0;
    m_sv = snap_req;
    if (snap_req) begin
      m_ssec = m_sec;
      m_ssub = s[31:0];
    end
    if (e) begin
      m_last = p[31:0];
      anchor = t;
      case (mode)
        FREE: begin mode = ACQ; run = 0; end
        ACQ: begin
          m_sec++;
          if (ok) begin
            run++;
            if (run == LOCKN) mode = TRACK;
          end else run = 0;
        end
        TRACK: begin
          m_sec++;
          iset = 1;
          if (!ok) begin eset = 1; mode = ACQ; run = 0; end
        end
        FLY: begin
          if (s >= NOM / 2) m_sec++;
          mode = ACQ; run = 0;
        end
      endcase
    end else if (mode == ACQ && p == NOM + TOL) begin
      mode = FREE;
    end else if (mode == TRACK && p == NOM + TOL) begin
      mode = FLY; m_sec++; anchor = t - TOL; iset = 1;
    end else if (mode == FLY && p == NOM) begin
      anchor = t; m_sec++;
    end
    m_irq = iset | (m_irq & !irq_ack);
    m_err = eset | (m_err & !irq_ack);
  endtask

  task automatic check_model();
    bit ok;
    ok = (seconds == m_sec) && (subsec == m_sub()) &&
         (last_period == m_last) && (snap_seconds == m_ssec) &&
         (snap_subsec == m_ssub) && (snap_valid == m_sv) &&
         (locked == (mode == TRACK)) && (holdover == (mode == FLY)) &&
         (pps_err == m_err) && (irq == m_irq);
    checks++;
    if (ok) passed++;
    else $display("FAIL model t=%0d dut sec=%0d sub=%0d last=%0d snap=%0d/%0d sv=%0b lk=%0b ho=%0b err=%0b irq=%0b ref sec=%0d sub=%0d last=%0d snap=%0d/%0d sv=%0b lk=%0b ho=%0b err=%0b irq=%0b",
                  t, seconds, subsec, last_period, snap_seconds, snap_subsec,
                  snap_valid, locked, holdover, pps_err, irq,
                  m_sec, m_sub(), m_last, m_ssec, m_ssub, m_sv,
                  mode == TRACK, mode == FLY, m_err, m_irq);
  endtask

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic pulse_update(input bit snap);
    pps_in = 1'b1;
    tick();
    pps_in = 1'b0;
    tick();
    snap_req = snap;
    tick();
    snap_req = 1'b0;
  endtask

  // Arrange for the synced edge to land while subsec == k.
  task automatic edge_at(input int k, input bit snap);
    repeat (k - 2 - int'(m_sub())) tick();
    pulse_update(snap);
  endtask

  typedef struct {
    int per;
    int sec;
    bit lk;
    bit irq;
    int last;
  } vec_t;
  vec_t tbl[6];

  task automatic run_lock_table();
    for (int i = 0; i < 6; i++) begin
      edge_at(tbl[i].per - 1, 1'b0);
      chk($sformatf("lock%0d_sec", i), seconds, tbl[i].sec);
      chk($sformatf("lock%0d_locked", i), locked, tbl[i].lk);
      chk($sformatf("lock%0d_irq", i), irq, tbl[i].irq);
      chk($sformatf("lock%0d_last", i), last_period, tbl[i].last);
      chk($sformatf("lock%0d_subsec", i), subsec, 0);
    end
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int periods[9];
    int p, w;
    periods = '{100, 99, 101, 102, 98, 95, 104, 250, 130};
    tbl[0] = '{10, 0, 0, 0, 10};
    tbl[1] = '{100, 1, 0, 0, 100};
    tbl[2] = '{100, 2, 0, 0, 100};
    tbl[3] = '{100, 3, 1, 0, 100};
    tbl[4] = '{100, 4, 1, 1, 100};
    tbl[5] = '{101, 5, 1, 1, 101};

    model_reset();
    repeat (3) tick();
    chk("rst_seconds", seconds, 0);
    chk("rst_subsec", subsec, 0);
    chk("rst_locked", locked, 0);
    chk("rst_irq", irq, 0);
    rst_n = 1'b1;

    run_lock_table();

    repeat (101) tick();
    chk("ho_not_yet", holdover, 0);
    tick();
    chk("ho_enter", holdover, 1);
    chk("ho_seconds", seconds, 6);
    chk("ho_subsec", subsec, 2);
    chk("ho_irq", irq, 1);
    repeat (97) tick();
    chk("fly_hold", seconds, 6);
    tick();
    chk("fly_wrap_sec", seconds, 7);
    chk("fly_wrap_sub", subsec, 0);

    edge_at(30, 1'b0);
    chk("ho_early_sec", seconds, 7);
    chk("ho_early_sub", subsec, 0);
    chk("ho_early_ho", holdover, 0);
    chk("ho_early_last", last_period, 31);
    edge_at(99, 1'b0);
    edge_at(99, 1'b0);
    chk("relock_wait", locked, 0);
    edge_at(99, 1'b0);
    chk("relock", locked, 1);
    chk("relock_sec", seconds, 10);

    repeat (102) tick();
    chk("ho2_enter", holdover, 1);
    chk("ho2_sec", seconds, 11);
    edge_at(70, 1'b0);
    chk("ho_late_sec", seconds, 12);
    chk("ho_late_sub", subsec, 0);
    repeat (3) edge_at(99, 1'b0);
    chk("relock2", locked, 1);
    ack();
    chk("ack_irq", irq, 0);

    edge_at(94, 1'b0);
    chk("bad_err", pps_err, 1);
    chk("bad_locked", locked, 0);
    chk("bad_irq", irq, 1);
    chk("bad_sec", seconds, 16);
    ack();
    chk("bad_ack_irq", irq, 0);
    chk("bad_ack_err", pps_err, 0);

    edge_at(99, 1'b1);
    chk("snap_valid", snap_valid, 1);
    chk("snap_sec", snap_seconds, 16);
    chk("snap_sub", snap_subsec, 99);
    chk("snap_live_sec", seconds, 17);
    tick();
    chk("snap_valid_drop", snap_valid, 0);
    edge_at(99, 1'b0);
    edge_at(99, 1'b0);
    chk("relock3", locked, 1);
    edge_at(99, 1'b0);
    chk("pre_rst_irq", irq, 1);

    repeat (40) tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_seconds", seconds, 0);
    chk("arst_subsec", subsec, 0);
    chk("arst_last", last_period, 0);
    chk("arst_snap_sec", snap_seconds, 0);
    chk("arst_snap_sub", snap_subsec, 0);
    chk("arst_locked", locked, 0);
    chk("arst_irq", irq, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    run_lock_table();

    for (int n = 0; n < 40; n++) begin
      p = periods[$urandom_range(0, 8)];
      w = $urandom_range(1, 4);
      for (int i = 0; i < p; i++) begin
        pps_in = (i < w);
        snap_req = ($urandom_range(0, 7) == 0);
        irq_ack = ($urandom_range(0, 15) == 0);
        tick();
      end
    end
    pps_in = 1'b0;
    snap_req = 1'b0;
    irq_ack = 1'b0;
    repeat (5) tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
